// File: rtl/sb_ctrl_pkg.sv
// sb_ctrl_pkg: bus address map and data type shared by the *_sb_ctrl peripherals
package sb_ctrl_pkg;
  typedef logic [31:0] sb_data_t;
  localparam sb_data_t SB_VAL_ADDR  = 32'h0;
  localparam sb_data_t SB_MODE_ADDR = 32'h4;
  localparam sb_data_t SB_RST_ADDR  = 32'h24;
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser and whole-vector debouncer, pulses change when sw_val commits
module sw_debounce #(
  parameter int WIDTH = 16,
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_val,
  output logic             change
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [WIDTH-1:0] q1, q2, cand;
  logic [CW-1:0] cnt;
  assign change = (q2 == cand) && (cnt == CW'(DEBOUNCE_CYCLES - 1)) && (cand != sw_val);
  always_ff @(posedge clk) begin
    if (rst) begin
      q1 <= '0;
      q2 <= '0;
      cand <= '0;
      cnt <= '0;
      sw_val <= '0;
    end else begin
      q1 <= sw;
      q2 <= q1;
      if (q2 != cand) begin
        cand <= q2;
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) cnt <= CW'(DEBOUNCE_CYCLES);
      else if (cnt < CW'(DEBOUNCE_CYCLES)) cnt <= cnt + CW'(1);
      if (change) sw_val <= cand;
    end
  end
endmodule

// File: rtl/sw_sb_ctrl.sv
// sw_sb_ctrl: bus-mapped debounced switch reader with change interrupt (value 0x00, irq_en 0x04, soft reset 0x24)
module sw_sb_ctrl
  import sb_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        write_enable_i,
  input  logic [31:0] addr_i,
  input  sb_data_t    write_data_i,
  output sb_data_t    read_data_o,
  input  logic [15:0] sw_i,
  output logic        interrupt_request_o,
  input  logic        interrupt_return_i
);
  logic [15:0] sw_val;
  logic change, irq_en, wr, rd, soft_rst, rst;
  assign wr = req_i & write_enable_i;
  assign rd = req_i & ~write_enable_i;
  assign soft_rst = wr && addr_i == SB_RST_ADDR && write_data_i == 32'd1;
  assign rst = rst_i | soft_rst;
  sw_debounce #(.WIDTH(16), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk_i), .rst(rst), .sw(sw_i), .sw_val(sw_val), .change(change)
  );
  always_ff @(posedge clk_i) begin
    if (rst) begin
      irq_en <= 1'b0;
      interrupt_request_o <= 1'b0;
      read_data_o <= '0;
    end else begin
      if (wr && addr_i == SB_MODE_ADDR && write_data_i < 32'd2) irq_en <= write_data_i[0];
      // a new change takes priority over a same-cycle acknowledge
      if (change && irq_en) interrupt_request_o <= 1'b1;
      else if (interrupt_return_i) interrupt_request_o <= 1'b0;
      if (rd && addr_i == SB_VAL_ADDR) read_data_o <= {16'd0, sw_val};
      else if (rd && addr_i == SB_MODE_ADDR) read_data_o <= {31'd0, irq_en};
    end
  end
endmodule

// File: tb/tb_sw_sb_ctrl.sv
// tb_sw_sb_ctrl: self-checking bench for sw_sb_ctrl with DEBOUNCE_CYCLES = 4
module tb_sw_sb_ctrl;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, ret = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [15:0] sw = '0;
  logic irq;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  sw_sb_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .write_enable_i(we), .addr_i(addr),
    .write_data_i(wdata), .read_data_o(rdata), .sw_i(sw),
    .interrupt_request_o(irq), .interrupt_return_i(ret)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    req = 1'b0; we = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string name);
    logic [31:0] x;
    req = 1'b1; we = 1'b0; addr = a;
    exp_q.push_back(e);
    tick();
    req = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, read_data_o=%h", name, rdata);
    end else begin
      x = exp_q.pop_front();
      if (rdata !== x) begin
        errors++;
        $display("FAIL %s: read_data_o=%h expected %h", name, rdata, x);
      end
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    checks++;
    if (rdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset: read_data_o=%h irq=%b expected 0/0", rdata, irq);
    end
    rd(32'h0, 32'h0, "reset_val");
    rd(32'h4, 32'h0, "reset_irq_en");
  endtask
  task automatic test_change_irq;
    wr(32'h4, 32'd1);
    sw = 16'hA5A5;
    tick(6);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL early_irq: irq=%b expected 0 at edge 6", irq);
    end
    rd(32'h0, 32'h0, "same_edge_read_old");
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: irq=%b expected 1 at edge 7", irq);
    end
    rd(32'h0, 32'h0000A5A5, "sw_val_a5a5");
    ret = 1'b1;
    tick();
    ret = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_ack: irq=%b expected 0", irq);
    end
  endtask
  task automatic test_bounce;
    rst = 1'b1; sw = '0;
    tick();
    rst = 1'b0;
    wr(32'h4, 32'd1);
    tick(6);
    sw = 16'h0001; tick(2);
    sw = 16'h0000; tick(2);
    sw = 16'h0001; tick(2);
    sw = 16'h0000; tick(12);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL bounce_irq: irq=%b expected 0", irq);
    end
    rd(32'h0, 32'h0, "bounce_val");
  endtask
  task automatic test_irq_en_disable;
    wr(32'h4, 32'd5);
    rd(32'h4, 32'h1, "irq_en_invalid_write");
    wr(32'h4, 32'd0);
    rd(32'h4, 32'h0, "irq_en_cleared");
    wr(32'h0, 32'h1234);
    sw = 16'h00FF;
    tick(10);
    rd(32'h0, 32'h000000FF, "sw_val_00ff");
    rd(32'h8, 32'h000000FF, "unmapped_read_holds");
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL disabled_irq: irq=%b expected 0", irq);
    end
  endtask
  task automatic test_change_vs_ack;
    wr(32'h4, 32'd1);
    sw = 16'h0F0F;
    tick(7);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL pending_irq: irq=%b expected 1", irq);
    end
    sw = 16'hF0F0;
    tick(6);
    ret = 1'b1;
    tick();
    ret = 1'b0;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL change_vs_ack: irq=%b expected 1", irq);
    end
    rd(32'h0, 32'h0000F0F0, "sw_val_f0f0");
  endtask
  task automatic test_soft_reset;
    sw = 16'hFFFF;
    tick(3);
    wr(32'h24, 32'd1);
    checks++;
    if (rdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL soft_reset: read_data_o=%h irq=%b expected 0/0", rdata, irq);
    end
    rd(32'h4, 32'h0, "soft_reset_irq_en");
    rd(32'h0, 32'h0, "soft_reset_val");
    tick(4);
    rd(32'h0, 32'h0, "soft_reset_edge7_old");
    rd(32'h0, 32'h0000FFFF, "soft_reset_ffff");
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL soft_reset_irq: irq=%b expected 0", irq);
    end
  endtask
  initial begin
    test_reset();
    test_change_irq();
    test_bounce();
    test_irq_en_disable();
    test_change_vs_ack();
    test_soft_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sw_sb_ctrl.md
# sw_sb_ctrl

Memory-mapped input peripheral for 16 board switches on the system bus, the read-side counterpart of the LED output controller. It synchronises and debounces `sw_i`, exposes the stable value through a registered read port, and raises an interrupt request on every debounced change. The interrupt is held until the core acknowledges it. It sits on the peripheral bus beside the other `*_sb_ctrl` units and feeds the interrupt controller.

## Interface
- `DEBOUNCE_CYCLES`, default 100_000: consecutive stable cycles required before a new switch value is accepted. Legal range is ≥ 2.
- `clk_i`  in  1  system clock; one clock domain.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_i`  in  1  bus request.
- `write_enable_i`  in  1  1 = write, 0 = read (qualified by `req_i`).
- `addr_i`  in  32  byte offset within the peripheral.
- `write_data_i`  in  32  write data.
- `read_data_o`  out  32  registered read data.
- `sw_i`  in  16  raw, asynchronous switch inputs.
- `interrupt_request_o`  out  1  level interrupt request.
- `interrupt_return_i`  in  1  interrupt acknowledge from the core (one-cycle pulse).

## Operation
- **Register map**
  - 0x00 `sw_val`: read-only. Returns `{16'd0, sw_val}`.
  - 0x04 `irq_en`: read/write. Returns `{31'd0, irq_en}`. A write takes effect only if `write_data_i < 2`.
  - 0x24 soft reset: write-only. Writing exactly 1 has the same effect as `rst_i` on that edge. Any other value is ignored.
- **Ignored accesses:** writes to 0x00, writes to unmapped addresses and invalid write values change nothing.
- **Reads:**
  - A read of 0x00 or 0x04 loads `read_data_o` on the next edge.
  - A read of any other address leaves `read_data_o` unchanged.
  - With no read request, `read_data_o` holds its value.
- **Synchroniser:** two flops, `sw_i` → `q1` → `q2`.
- **Debouncer:** whole-vector, per cycle.
  - If `q2 != cand`: `cand <= q2`, `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `cnt <= DEBOUNCE_CYCLES` (saturate), and if `cand != sw_val` then `sw_val <= cand` with a one-cycle internal `change` pulse.
  - Else if `cnt < DEBOUNCE_CYCLES`: `cnt <= cnt + 1`.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- **Interrupt:**
  - `interrupt_request_o` is set on `change & irq_en`.
  - It is cleared on `interrupt_return_i`.
  - If `change & irq_en` and `interrupt_return_i` occur in the same cycle, the request stays 1.
  - Clearing `irq_en` does not drop a pending request.
  - Changes that occur while `irq_en = 0` are not remembered.
- **Reset values** (`rst_i` or soft reset): `q1`, `q2`, `cand`, `sw_val`, `cnt`, `irq_en`, `interrupt_request_o` and `read_data_o` all go to 0.

## Timing
- **Bus:** zero-wait. A request is accepted in the cycle `req_i` is high. Read data is valid from the edge after the request and is held until the next valid read.
- **Switch latency:** counting the first edge that samples a new, stable `sw_i` as edge 1, `sw_val` and `interrupt_request_o` update at edge `DEBOUNCE_CYCLES+3`.
- **Glitch rejection:** a `q2` pulse shorter than `DEBOUNCE_CYCLES` cycles never reaches `sw_val`. A bounce back to the old value restarts the count and produces no change and no interrupt.
- **Write-vs-change collision:** a write to `irq_en` on the same edge as `change` uses the old `irq_en` value.
- **Same-edge read of `sw_val`:** a read of 0x00 on the same edge that `sw_val` updates returns the old value.
- **Reset mid-debounce:** reset discards the count. Because `cand` is reset to 0, a nonzero `sw_i` held through reset requires a full new debounce period after reset deasserts.
- **Soft reset and simultaneous events:** soft reset wins over a simultaneous `change`.

## Structure
- Shared package `sb_ctrl_pkg` holds:
  - address constants `SB_VAL_ADDR = 32'h0`, `SB_MODE_ADDR = 32'h4`, `SB_RST_ADDR = 32'h24`, shared with the LED controller;
  - the 32-bit bus data typedef.
- Sub-module `sw_debounce #(WIDTH, DEBOUNCE_CYCLES)` contains the synchroniser, candidate, counter and `sw_val`, and emits `change`.
- The top level holds address decode, `irq_en`, the interrupt flag and the read register.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`.
1. Reset, then read 0x00 and 0x04 → `read_data_o = 0` both times, `interrupt_request_o = 0`.
2. Write 1 to 0x04. Set `sw_i = 16'hA5A5` and hold → at edge 7 `sw_val = 16'hA5A5` and `interrupt_request_o = 1`. Read 0x00 → `32'h0000A5A5`. Pulse `interrupt_return_i` → request is 0 after the next edge.
3. `sw_i` bounces `0x0001 / 0x0000 / 0x0001` with 2-cycle segments, then settles at `0x0000` → `sw_val` stays 0 and no interrupt is raised.
4. Write 5 to 0x04 → `irq_en` unchanged. Write 0 to 0x04, change `sw_i` to `0x00FF` → `sw_val = 0x00FF`, no interrupt.
5. With `irq_en = 1` and a request pending, make a new change commit in the same cycle as an `interrupt_return_i` pulse → `interrupt_request_o` remains 1.
6. Write 1 to 0x24 mid-debounce with `sw_i = 0xFFFF` → all state is 0. `sw_val` becomes `0xFFFF` only at edge 7 after the reset cycle, and no interrupt is raised because `irq_en = 0`.
